// File: rtl/basic_handshake_requestor.sv
// basic_handshake_requestor: FIFO-fed valid/busy handshake initiator with request and release timeouts
module basic_handshake_requestor #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          push_valid,
  input  logic [DATA_W-1:0]             push_data,
  output logic                          push_ready,
  output logic                          valid,
  output logic [DATA_W-1:0]             data_out,
  input  logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          xfer_done,
  output logic                          timeout_err,
  input  logic                          err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WREL = 2'd2;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic [1:0]        r_state;
  logic [TW-1:0]     r_timer;
  logic              r_valid, r_done, r_err;
  logic [DATA_W-1:0] r_data;
  logic              w_full, w_empty, w_push, w_launch, w_tmo, w_set;
  always_comb begin
    w_full   = r_count == CW'(FIFO_DEPTH);
    w_empty  = r_count == '0;
    w_push   = push_valid && !w_full;
    w_launch = !w_empty && !busy && (r_state == S_IDLE || r_state == S_WREL);
    w_tmo    = r_timer == TW'(TIMEOUT - 1);
    // REQ times out waiting for busy to rise, WAIT_REL waiting for it to fall
    w_set    = w_tmo && ((r_state == S_REQ && !busy) || (r_state == S_WREL && busy));
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_state <= S_IDLE;
      r_timer <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= w_set || (r_err && !err_clr);
      r_count <= r_count + CW'(w_push) - CW'(w_launch);
      if (w_push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_launch) begin
        r_rptr  <= r_rptr + AW'(1);
        r_data  <= r_mem[r_rptr];
        r_valid <= 1'b1;
        r_timer <= '0;
        r_state <= S_REQ;
      end else if (r_state == S_REQ) begin
        if (busy || w_tmo) begin
          r_valid <= 1'b0;
          r_done  <= busy;
          r_timer <= '0;
          r_state <= S_WREL;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end else if (r_state == S_WREL) begin
        if (!busy || w_tmo) begin
          r_timer <= '0;
          r_state <= S_IDLE;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end
    end
  end
  assign push_ready  = !w_full;
  assign valid       = r_valid;
  assign data_out    = r_data;
  assign fifo_count  = r_count;
  assign xfer_done   = r_done;
  assign timeout_err = r_err;
endmodule

// File: tb/tb_basic_handshake_requestor.sv
// tb_basic_handshake_requestor: vector table, directed corner sequences and random traffic against a queue-based model
module tb_basic_handshake_requestor;
  localparam int DW = 4;
  localparam int D  = 4;
  localparam int TO = 15;
  logic          clk = 1'b0;
  logic          rstn, push_valid, busy, err_clr;
  logic [DW-1:0] push_data;
  logic          push_ready, valid, xfer_done, timeout_err;
  logic [DW-1:0] data_out;
  logic [2:0]    fifo_count;
  basic_handshake_requestor #(.DATA_W(DW), .FIFO_DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .valid(valid), .data_out(data_out), .busy(busy),
    .fifo_count(fifo_count), .xfer_done(xfer_done), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit ideal = 1'b0;
  int done_t[$];
  logic [DW-1:0] rcvd[$];
  // Reference: words wait in a queue; a word is "on the wire" while m_valid,
  // and m_owed means an acknowledged/abandoned word still waits for busy to drop.
  logic [DW-1:0] m_q[$];
  bit            m_valid, m_owed, m_done, m_err;
  logic [DW-1:0] m_data;
  int            m_age;
  always @(posedge clk) begin : model
    bit set, launch;
    int sz;
    if (rstn) begin
      m_q.delete();
      m_valid = 0; m_owed = 0; m_done = 0; m_err = 0; m_data = '0; m_age = 0;
    end else begin
      sz = m_q.size(); set = 0; launch = 0; m_done = 0;
      if (m_valid) begin
        if (busy) begin m_valid = 0; m_owed = 1; m_done = 1; m_age = 0; end
        else if (m_age + 1 == TO) begin m_valid = 0; m_owed = 1; set = 1; m_age = 0; end
        else m_age++;
      end else if (m_owed) begin
        if (!busy) begin m_owed = 0; launch = sz > 0; end
        else if (m_age + 1 == TO) begin m_owed = 0; set = 1; m_age = 0; end
        else m_age++;
      end else launch = sz > 0 && !busy;
      if (launch) begin m_data = m_q.pop_front(); m_valid = 1; m_age = 0; end
      if (push_valid && sz < D) m_q.push_back(push_data);
      m_err = set || (m_err && !err_clr);
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  task automatic step();
    logic v_pre;
    logic [10:0] act, exp;
    v_pre = valid;
    @(posedge clk);
    #1;
    cyc++;
    act = {push_ready, valid, data_out, fifo_count, xfer_done, timeout_err};
    exp = {m_q.size() < D, m_valid, m_data, 3'(m_q.size()), m_done, m_err};
    chk("model", int'(act), int'(exp));
    if (xfer_done) begin done_t.push_back(cyc); rcvd.push_back(data_out); end
    if (ideal) busy = v_pre;
  endtask
  typedef struct {
    logic pv; logic [DW-1:0] pd; logic bz;
    logic e_valid; logic [DW-1:0] e_data; logic e_done; logic [2:0] e_cnt;
  } vec_t;
  vec_t tv[11];
  initial begin
    int hi, n, nd;
    bit vmax, saw_full, pre;
    tv[0]  = '{1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 1'b0, 3'd1};
    tv[1]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'hA, 1'b0, 3'd0};
    tv[2]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'hA, 1'b0, 3'd0};
    tv[3]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'hA, 1'b1, 3'd0};
    tv[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'hA, 1'b0, 3'd0};
    tv[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 1'b0, 3'd0};
    tv[6]  = '{1'b1, 4'hB, 1'b1, 1'b0, 4'hA, 1'b0, 3'd1};
    tv[7]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'hA, 1'b0, 3'd1};
    tv[8]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'hB, 1'b0, 3'd0};
    tv[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'hB, 1'b1, 3'd0};
    tv[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'hB, 1'b0, 3'd0};
    rstn = 1; push_valid = 0; push_data = '0; busy = 0; err_clr = 0;
    step(); step();
    rstn = 0;
    chk("reset", int'({push_ready, valid, data_out, fifo_count, xfer_done, timeout_err}), 11'h400);
    for (int i = 0; i < 11; i++) begin
      push_valid = tv[i].pv; push_data = tv[i].pd; busy = tv[i].bz;
      step();
      chk($sformatf("vec%0d", i), int'({valid, data_out, xfer_done, fifo_count}),
          int'({tv[i].e_valid, tv[i].e_data, tv[i].e_done, tv[i].e_cnt}));
    end
    push_valid = 0;
    chk("vec_err", int'(timeout_err), 0);
    push_valid = 1; push_data = 4'h3; busy = 0;
    step();
    push_valid = 0;
    step(); step();
    busy = 1;
    step();
    chk("stuck_ack", int'({valid, xfer_done, data_out}), 6'h13);
    push_valid = 1; push_data = 4'h9;
    step();
    push_valid = 0; n = 1; vmax = 0;
    while (!timeout_err && n < 40) begin step(); n++; vmax |= valid; end
    chk("stuck_timeout_cycles", n, TO);
    repeat (3) begin step(); vmax |= valid; end
    chk("stuck_no_launch", int'({vmax, fifo_count}), 1);
    busy = 0; err_clr = 1;
    step();
    err_clr = 0;
    chk("stuck_relaunch", int'({valid, data_out, timeout_err}), 6'h32);
    ideal = 1;
    repeat (6) step();
    ideal = 0; busy = 0;
    nd = done_t.size();
    push_valid = 1; push_data = 4'h7;
    step();
    push_valid = 0;
    step();
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!valid) break;
      hi++;
      step();
    end
    chk("req_timeout_valid_cycles", hi, TO);
    chk("req_timeout_err", int'(timeout_err), 1);
    chk("req_timeout_no_done", done_t.size(), nd);
    step();
    err_clr = 1;
    step();
    err_clr = 0;
    chk("err_clear", int'(timeout_err), 0);
    push_valid = 1; push_data = 4'h5;
    step();
    push_valid = 0;
    step();
    chk("next_word_launch", int'({valid, data_out}), 5'h15);
    repeat (TO - 1) step();
    chk("still_req", int'(valid), 1);
    err_clr = 1;
    step();
    chk("set_wins", int'({valid, timeout_err}), 1);
    step();
    err_clr = 0;
    chk("clear_after", int'(timeout_err), 0);
    step();
    done_t.delete(); rcvd.delete();
    ideal = 1; busy = 0; saw_full = 0;
    for (int w = 1; w <= 6; w++) begin
      push_valid = 1; push_data = DW'(w);
      for (int k = 0; k < 20; k++) begin
        pre = push_ready;
        step();
        if (!push_ready) saw_full = 1;
        if (pre) break;
      end
    end
    push_valid = 0;
    repeat (30) step();
    chk("burst_saw_full", int'(saw_full), 1);
    chk("burst_count", rcvd.size(), 6);
    for (int i = 0; i < rcvd.size(); i++) chk($sformatf("burst_word%0d", i), int'(rcvd[i]), i + 1);
    for (int i = 1; i < done_t.size(); i++) chk($sformatf("burst_gap%0d", i), done_t[i] - done_t[i-1], 4);
    ideal = 0; busy = 0;
    for (int w = 0; w < 4; w++) begin
      push_valid = 1; push_data = DW'(4'hC + w);
      step();
    end
    push_valid = 0;
    chk("pre_reset_req", int'({valid, fifo_count}), 4'hB);
    rstn = 1;
    step();
    rstn = 0;
    chk("mid_reset", int'({valid, fifo_count, data_out, xfer_done}), 0);
    step();
    chk("mid_reset_no_done", int'(xfer_done), 0);
    for (int s = 0; s < 20; s++) begin
      int mode;
      mode = $urandom_range(0, 3);
      ideal = mode == 0;
      for (int c = 0; c < 30; c++) begin
        push_valid = 1'($urandom_range(0, 1));
        push_data  = DW'($urandom);
        err_clr    = $urandom_range(0, 7) == 0;
        rstn       = $urandom_range(0, 199) == 0;
        if (mode == 1) busy = 0;
        else if (mode == 2) busy = 1;
        else if (mode == 3) busy = 1'($urandom_range(0, 1));
        step();
      end
    end
    rstn = 0; push_valid = 0; err_clr = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/basic_handshake_requestor.md
Name: basic_handshake_requestor

Overview:
- Initiator side of the basic valid/busy handshake. Drives `valid` and `data_out` into the completer and uses the completer's `busy` as the acknowledge.
- A small internal FIFO decouples the upstream producer from the handshake. Each word is presented until it is acknowledged, then released.
- A timeout flags a completer that never acknowledges or never releases.

Parameters:
- DATA_W, 4, payload width; matches the completer's data width.
- FIFO_DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- TIMEOUT, 15, maximum cycles spent in REQ or WAIT_REL before an error is flagged; at least 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  reset, synchronous and active-high (1 = reset asserted).
- push_valid  in  1  upstream write strobe.
- push_data  in  DATA_W  upstream write data.
- push_ready  out  1  FIFO not full.
- valid  out  1  request to the completer.
- data_out  out  DATA_W  payload to the completer.
- busy  in  1  completer acknowledge.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- xfer_done  out  1  one-cycle pulse when a word is acknowledged.
- timeout_err  out  1  sticky error flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (rstn=1 at a clock edge):
  - valid=0, data_out=0, xfer_done=0, timeout_err=0.
  - FIFO emptied: fifo_count=0, push_ready=1.
  - Timer=0, state=IDLE.
  - Reset in the middle of a transfer abandons it; valid is 0 after the reset edge.
- All outputs are registered, except push_ready, which is ~full decoded from registered occupancy.
- FIFO:
  - Write when push_valid && push_ready.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - There is no bypass: a word pushed into an empty FIFO can launch no earlier than the following edge.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: if FIFO not empty and busy==0, pop the head into data_out, set valid=1, clear the timer, go to REQ. If busy==1 in IDLE, do not launch.
  - REQ: valid=1 and data_out held stable.
    - If busy==1: set valid=0, pulse xfer_done, clear the timer, go to WAIT_REL.
    - Else increment the timer. When the timer reaches TIMEOUT-1 with busy still 0: set valid=0, set timeout_err=1, drop the word (no retry), go to WAIT_REL.
  - WAIT_REL: valid=0.
    - If busy==0 and FIFO not empty: pop, set valid=1, clear the timer, go to REQ (back-to-back launch).
    - If busy==0 and FIFO empty: go to IDLE.
    - If busy stays 1 for TIMEOUT cycles: set timeout_err=1, go to IDLE.
- data_out keeps the last launched value while valid=0.
- Timing against a completer that registers busy one edge after valid:
  - valid rises at edge E0; busy rises at E1.
  - valid falls and xfer_done=1 at E2; busy falls at E3.
  - The next launch is at E4, giving a throughput of 1 word per 4 cycles when the FIFO is non-empty.
- timeout_err:
  - Set by either timeout; cleared by err_clr.
  - If a set and err_clr occur in the same cycle, set wins.
  - A timeout does not block further transfers.
- busy rising while in IDLE (spurious) is ignored apart from inhibiting launch.

Test Plan:
- Reset and single word:
  - Stimulus: reset 2 cycles, push 4'hA, ideal completer.
  - Required: valid=1 with data_out=A for exactly 2 cycles; completer data_rcvd=A; one xfer_done pulse; fifo_count 1→0; timeout_err=0.
- Burst and full:
  - Stimulus: push 4'h1..4'h5 on consecutive cycles, FIFO_DEPTH=4.
  - Required: push_ready=0 once 4 words are held. The 5th word is either accepted only after the first pop, or dropped if push_valid is deasserted. Words are delivered in order with a 4-cycle spacing; 5 xfer_done pulses.
- Request timeout:
  - Stimulus: busy tied to 0, push 4'h7, TIMEOUT=15.
  - Required: valid high for 15 cycles then low; timeout_err=1; no xfer_done; FSM returns to IDLE; the next pushed word launches.
- Stuck busy:
  - Stimulus: after acknowledge, hold busy=1 indefinitely.
  - Required: valid stays 0; timeout_err=1 after 15 cycles in WAIT_REL; no launch while busy=1.
- Error clear collision:
  - Stimulus: assert err_clr in the same cycle a timeout fires, then again 1 cycle later.
  - Required: timeout_err stays 1 after the first, then reads 0.
- Reset mid-transfer:
  - Stimulus: assert rstn while in REQ with 3 words queued.
  - Required: after that edge, valid=0, fifo_count=0, data_out=0; no xfer_done pulse.
